// File: rtl/approx_div.sv
`default_nettype none
// ============================================================================
//  Module      : approx_div
//  Description : Sequential approximate unsigned divider, 16-bit dividend by
//                8-bit divisor. Only the K most significant quotient positions
//                (anchored at the leading ones of both operands) are
//                evaluated. Lower quotient bits are left at zero. The
//                remainder is exact for the truncated quotient. Ready/valid
//                handshakes are used on both sides, and one operation is in
//                flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_div #(
    parameter int K = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] N,
    input  logic [7:0]  D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_k = 5'(K);

    state_t      r_state;
    logic [15:0] r_n;
    logic [7:0]  r_d;
    logic [15:0] r_rem;
    logic [3:0]  r_idx;
    logic [4:0]  r_cnt;
    logic [15:0] r_q;
    logic [15:0] r_r;
    logic        r_dz;
    logic        r_in_ready;
    logic        r_out_valid;

    logic [3:0]  w_lod_n;
    logic [2:0]  w_lod_d;
    logic [3:0]  w_s;
    logic [4:0]  w_s_p1;
    logic [4:0]  w_npos;
    logic [23:0] w_shifted;
    logic        w_take;
    logic [15:0] w_rem_next;

    function automatic logic [3:0] lod16(input logic [15:0] v);
        lod16 = 4'd0;
        for (int b = 0; b < 16; b++) begin
            if (v[b]) lod16 = 4'(b);
        end
    endfunction

    function automatic logic [2:0] lod8(input logic [7:0] v);
        lod8 = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) lod8 = 3'(b);
        end
    endfunction

    // Normalisation: top quotient position and number of positions to evaluate
    always_comb begin
        w_lod_n = lod16(r_n);
        w_lod_d = lod8(r_d);
        w_s     = w_lod_n - {1'b0, w_lod_d};
        w_s_p1  = {1'b0, w_s} + 5'd1;
        w_npos  = (w_s_p1 > c_k) ? c_k : w_s_p1;
    end

    // One restoring-division step; the compare is full width so D<<15 is exact.
    // When the subtract happens the shifted divisor fits in 16 bits, so the
    // narrow subtraction is lossless.
    always_comb begin
        w_shifted  = {16'd0, r_d} << r_idx;
        w_take     = ({8'd0, r_rem} >= w_shifted);
        w_rem_next = w_take ? (r_rem - w_shifted[15:0]) : r_rem;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= 16'd0;
            r_d         <= 8'd0;
            r_rem       <= 16'd0;
            r_idx       <= 4'd0;
            r_cnt       <= 5'd0;
            r_q         <= 16'd0;
            r_r         <= 16'd0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_n        <= N;
                        r_d        <= D;
                        r_q        <= 16'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_d == 8'd0) begin
                        r_q         <= 16'hFFFF;
                        r_r         <= r_n;
                        r_dz        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if ((r_n == 16'd0) || (w_lod_n < {1'b0, w_lod_d})) begin
                        r_q         <= 16'd0;
                        r_r         <= r_n;
                        r_dz        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_dz    <= 1'b0;
                        r_idx   <= w_s;
                        r_cnt   <= w_npos;
                        r_rem   <= r_n;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (w_take) r_q[r_idx] <= 1'b1;
                    r_rem <= w_rem_next;
                    r_idx <= r_idx - 4'd1;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_r         <= w_rem_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Q         = r_q;
    assign R         = r_r;
    assign dz        = r_dz;

endmodule
`default_nettype wire
